vga_timing_driver: RTL and testbench

//  Display-side end of the scene interface: generates h_cnt/v_cnt for scene modules, samples their 12-bit
//  vga_data, and drives the 640x480@60Hz VGA pins. Derives a 25 MHz pixel tick from 100 MHz clk via enable
//  (no derived clock). Delays sync/valid by the scene+image-memory read latency so colour aligns with syncs.

---
 rtl/vga_timing_driver.sv | 146 ++++++++++++++
 tb/tb_vga_timing_driver.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_driver.sv
// 640x480@60 VGA timing: pixel-tick divider, h/v counters, sync/valid alignment to scene read latency.
// Optional TEST_PATTERN_EN macro replaces pixel_data_in with five vertical colour bars.
module vga_timing_driver #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 4,
    parameter int PIPE_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] pixel_data_in,
    output logic [9:0]  h_cnt,
    output logic [9:0]  v_cnt,
    output logic        valid,
    output logic        pix_tick,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    typedef struct packed {
        logic       vld;
        logic       hs;
        logic       vs;
`ifdef TEST_PATTERN_EN
        logic [9:0] h;
`endif
    } pipe_t;

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d, v_q, v_d;
    logic             fs_q, fs_d;
    logic             hs_q, vs_q;
    logic [11:0]      rgb_q, colour;
    pipe_t            raw, del;

    always_comb begin
        div_d = (div_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_q + 1'b1;
        h_d   = h_q + 10'd1;
        v_d   = v_q;
        fs_d  = 1'b0;
        if (h_q == 10'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == 10'(V_TOTAL - 1)) ? 10'd0 : v_q + 10'd1;
            fs_d = pix_tick && (v_q == 10'(V_TOTAL - 1));
        end
    end

    always_comb begin
        raw.vld = ({1'b0, h_q} < 11'(H_VISIBLE)) && ({1'b0, v_q} < 11'(V_VISIBLE));
        raw.hs  = !(({1'b0, h_q} >= 11'(H_VISIBLE + H_FP)) &&
                    ({1'b0, h_q} <  11'(H_VISIBLE + H_FP + H_SYNC)));
        raw.vs  = !(({1'b0, v_q} >= 11'(V_VISIBLE + V_FP)) &&
                    ({1'b0, v_q} <  11'(V_VISIBLE + V_FP + V_SYNC)));
`ifdef TEST_PATTERN_EN
        raw.h   = h_q;
`endif
    end

    // Blank-with-syncs-inactive is the reset content of every alignment stage.
    generate
        if (PIPE_LAT == 0) begin : g_nopipe
            assign del = raw;
        end else begin : g_pipe
            pipe_t stage_q [PIPE_LAT];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIPE_LAT; i++) begin
                        stage_q[i]     <= '0;
                        stage_q[i].hs  <= 1'b1;
                        stage_q[i].vs  <= 1'b1;
                    end
                end else if (pix_tick) begin
                    stage_q[0] <= raw;
                    for (int i = 1; i < PIPE_LAT; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end
            assign del = stage_q[PIPE_LAT-1];
        end
    endgenerate

`ifdef TEST_PATTERN_EN
    always_comb begin
        colour = 12'h000;
        case (del.h[9:7])
            3'd0:    colour = 12'hfff;
            3'd1:    colour = 12'hff0;
            3'd2:    colour = 12'h0ff;
            3'd3:    colour = 12'h0f0;
            3'd4:    colour = 12'hf0f;
            default: colour = 12'h000;
        endcase
    end
`else
    assign colour = pixel_data_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
            fs_q  <= 1'b0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            rgb_q <= '0;
        end else begin
            div_q <= div_d;
            fs_q  <= fs_d;
            if (pix_tick) begin
                h_q   <= h_d;
                v_q   <= v_d;
                hs_q  <= del.hs;
                vs_q  <= del.vs;
                rgb_q <= del.vld ? colour : 12'h000;
            end
        end
    end

    assign pix_tick    = (div_q == DIV_W'(CLK_DIV - 1));
    assign h_cnt       = h_q;
    assign v_cnt       = v_q;
    assign valid       = raw.vld;
    assign frame_start = fs_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];

endmodule

// File: tb/tb_vga_timing_driver.sv
// Directed bench for vga_timing_driver on a shrunken 40x17 raster (20x10 visible), CLK_DIV=4, PIPE_LAT=1.
module tb_vga_timing_driver;

    localparam int HV = 20, HF = 4, HS = 6, HB = 10;
    localparam int VV = 10, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [11:0] pixel_data_in = 12'hA5C;
    logic [9:0]  h_cnt, v_cnt;
    logic        valid, pix_tick, frame_start, hsync, vsync;
    logic [3:0]  vga_r, vga_g, vga_b;

    int n_chk = 0;
    int n_pass = 0;

    vga_timing_driver #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(DIV), .PIPE_LAT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pixel_data_in(pixel_data_in),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid), .pix_tick(pix_tick),
        .frame_start(frame_start), .hsync(hsync), .vsync(vsync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          h;
        int          v;
        logic [11:0] pix;
        logic        vld;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Lands on the first negedge after the tick that moves the counters to (h,v).
    task automatic goto(input int h, input int v);
        bit found = 0;
        for (int i = 0; i < 2 * HT * VT * DIV && !found; i++) begin
            @(negedge clk);
            if (pix_tick) begin
                @(negedge clk);
                if (h_cnt == 10'(h) && v_cnt == 10'(v)) found = 1;
            end
        end
        chk($sformatf("goto_%0d_%0d", h, v), int'(found), 1);
    endtask

    function automatic logic [11:0] exp_rgb(input logic [11:0] r);
`ifdef TEST_PATTERN_EN
        return (r != 12'h000) ? 12'hfff : 12'h000;
`else
        return r;
`endif
    endfunction

    vec_t vecs[$];
    int   cnt;

    initial begin
        // Outputs at sample (h,v) reflect raw timing of the position two ticks earlier.
        vecs.push_back('{1,  3,  12'hA5C, 1, 1, 1, 12'h000});
        vecs.push_back('{2,  3,  12'hA5C, 1, 1, 1, 12'hA5C});
        vecs.push_back('{5,  3,  12'h3C7, 1, 1, 1, 12'h3C7});
        vecs.push_back('{21, 3,  12'hFFF, 0, 1, 1, 12'hFFF});
        vecs.push_back('{22, 3,  12'hFFF, 0, 1, 1, 12'h000});
        vecs.push_back('{25, 3,  12'h001, 0, 1, 1, 12'h000});
        vecs.push_back('{26, 3,  12'h001, 0, 0, 1, 12'h000});
        vecs.push_back('{31, 3,  12'h001, 0, 0, 1, 12'h000});
        vecs.push_back('{32, 3,  12'h001, 0, 1, 1, 12'h000});
        vecs.push_back('{5,  10, 12'hA5C, 0, 1, 1, 12'h000});
        vecs.push_back('{1,  12, 12'hA5C, 0, 1, 1, 12'h000});
        vecs.push_back('{2,  12, 12'hA5C, 0, 1, 0, 12'h000});
        vecs.push_back('{1,  14, 12'hA5C, 0, 1, 0, 12'h000});
        vecs.push_back('{2,  14, 12'hA5C, 0, 1, 1, 12'h000});
        vecs.push_back('{1,  0,  12'h3C7, 1, 1, 1, 12'h000});
        vecs.push_back('{2,  0,  12'h3C7, 1, 1, 1, 12'h3C7});

        #1 rst_n = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_h", int'(h_cnt), 0);
        chk("rst_v", int'(v_cnt), 0);
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_vsync", int'(vsync), 1);
        chk("rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
        chk("rst_tick", int'(pix_tick), 0);
        chk("rst_fs", int'(frame_start), 0);

        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("tick_edge%0d", k), int'(pix_tick), int'(k % DIV == DIV - 1));
            if (k == DIV - 1) chk("h_before_first_tick", int'(h_cnt), 0);
            if (k == DIV)     chk("h_after_first_tick", int'(h_cnt), 1);
        end

        foreach (vecs[i]) begin
            pixel_data_in = vecs[i].pix;
            goto(vecs[i].h, vecs[i].v);
            chk($sformatf("v%0d_valid", i), int'(valid), int'(vecs[i].vld));
            chk($sformatf("v%0d_hsync", i), int'(hsync), int'(vecs[i].hs));
            chk($sformatf("v%0d_vsync", i), int'(vsync), int'(vecs[i].vs));
            chk($sformatf("v%0d_rgb", i), int'({vga_r, vga_g, vga_b}), int'(exp_rgb(vecs[i].rgb)));
        end

        goto(HT - 1, 5);
        goto(0, 6);
        chk("line_wrap_fs", int'(frame_start), 0);

        goto(HT - 1, VT - 1);
        chk("pre_wrap_fs", int'(frame_start), 0);
        goto(0, 0);
        chk("frame_start_pulse", int'(frame_start), 1);
        @(negedge clk);
        chk("frame_start_one_clk", int'(frame_start), 0);

        goto(0, 3);
        cnt = 0;
        for (int i = 0; i < HT * DIV; i++) begin
            if (!hsync) cnt++;
            @(negedge clk);
        end
        chk("hsync_low_clks", cnt, HS * DIV);

        goto(0, 0);
        cnt = 0;
        for (int i = 0; i < HT * VT * DIV; i++) begin
            if (!vsync) cnt++;
            @(negedge clk);
        end
        chk("vsync_low_clks", cnt, VS * HT * DIV);

        pixel_data_in = 12'hA5C;
        goto(15, 7);
        chk("pre_rst_rgb", int'({vga_r, vga_g, vga_b}), int'(exp_rgb(12'hA5C)));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_h", int'(h_cnt), 0);
        chk("mid_rst_v", int'(v_cnt), 0);
        chk("mid_rst_hsync", int'(hsync), 1);
        chk("mid_rst_vsync", int'(vsync), 1);
        chk("mid_rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 1; k <= DIV; k++) begin
            @(negedge clk);
            if (frame_start) cnt++;
        end
        chk("mid_rst_no_fs", cnt, 0);
        chk("restart_h", int'(h_cnt), 1);
        chk("restart_v", int'(v_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
